// File: rtl/morse_pattern_player.sv
// Plays a latched sequence of Morse symbols on an active-low buzzer pin, with optional auto-repeat.
// Define MORSE_TONE_EN to toggle the pin at a tone rate during marks (passive buzzer).
module morse_pattern_player #(
  parameter int unsigned UNIT_CYC   = 2_500_000,
  parameter int unsigned DOT_UNITS  = 2,
  parameter int unsigned DASH_UNITS = 6,
  parameter int unsigned GAP_UNITS  = 1,
  parameter int unsigned WORD_UNITS = 4,
  parameter int unsigned MAX_SYM    = 16,
  parameter int unsigned TONE_HALF  = 12_500
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Start,
  input  logic                         Stop,
  input  logic                         Repeat,
  input  logic [2*MAX_SYM-1:0]         Pattern,
  input  logic [$clog2(MAX_SYM+1)-1:0] Sym_Cnt,
  output logic                         Pin_Out,
  output logic                         Busy,
  output logic                         Done
);

  localparam int unsigned CntW  = $clog2(MAX_SYM + 1);
  localparam int unsigned PreW  = $clog2(UNIT_CYC);
  localparam int unsigned MarkU = (DOT_UNITS > DASH_UNITS) ? DOT_UNITS : DASH_UNITS;
  localparam int unsigned SpcU  = (GAP_UNITS > WORD_UNITS) ? GAP_UNITS : WORD_UNITS;
  localparam int unsigned MaxU  = (MarkU > SpcU) ? MarkU : SpcU;
  localparam int unsigned UnitW = (MaxU < 2) ? 1 : $clog2(MaxU);

  localparam logic [PreW-1:0]  PreLast  = PreW'(UNIT_CYC - 1);
  localparam logic [UnitW-1:0] DotLast  = UnitW'(DOT_UNITS - 1);
  localparam logic [UnitW-1:0] DashLast = UnitW'(DASH_UNITS - 1);
  localparam logic [UnitW-1:0] GapLast  = UnitW'(GAP_UNITS - 1);
  localparam logic [UnitW-1:0] WordLast = UnitW'(WORD_UNITS - 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(MAX_SYM);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMark,
    StGap,
    StSpace,
    StFin
  } state_e;

  state_e               state_q, state_d;
  logic [2*MAX_SYM-1:0] pat_q, pat_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      idx_q, idx_d;
  logic [PreW-1:0]      pre_q, pre_d;
  logic [UnitW-1:0]     unit_q, unit_d;
  logic [UnitW-1:0]     mark_last_q, mark_last_d;
  logic                 pin_q, pin_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [1:0]           sym_cur;
  logic [UnitW-1:0]     unit_last;
  logic                 unit_done;

`ifdef MORSE_TONE_EN
  localparam int unsigned ToneW = (TONE_HALF < 2) ? 1 : $clog2(TONE_HALF);
  localparam logic [ToneW-1:0] ToneLast = ToneW'(TONE_HALF - 1);
  logic [ToneW-1:0] tone_q, tone_d;
`endif

  always_comb begin
    sym_cur = 2'b11;
    for (int k = 0; k < MAX_SYM; k++) begin
      if (idx_q == CntW'(k)) sym_cur = pat_q[2*k +: 2];
    end
  end

  always_comb begin
    unit_last = '0;
    case (state_q)
      StMark:  unit_last = mark_last_q;
      StGap:   unit_last = GapLast;
      StSpace: unit_last = WordLast;
      default: unit_last = '0;
    endcase
  end

  assign unit_done = (pre_q == PreLast) && (unit_q == unit_last);

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mark_last_d = mark_last_q;
    pin_d       = pin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef MORSE_TONE_EN
    tone_d      = '0;
`endif

    if (Stop && (state_q != StIdle)) begin
      state_d = StIdle;
      pin_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start && !Stop) begin
            pat_d   = Pattern;
            cnt_d   = (Sym_Cnt > CntMax) ? CntMax : Sym_Cnt;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = StLoad;
          end
        end
        StLoad: begin
          if ((idx_q == cnt_q) || (sym_cur == 2'b11)) begin
            state_d = StFin;
          end else if (sym_cur == 2'b10) begin
            state_d = StSpace;
          end else begin
            mark_last_d = (sym_cur == 2'b00) ? DotLast : DashLast;
            pin_d       = 1'b0;
            state_d     = StMark;
          end
        end
        StMark: begin
`ifdef MORSE_TONE_EN
          if (tone_q == ToneLast) begin
            tone_d = '0;
            pin_d  = ~pin_q;
          end else begin
            tone_d = tone_q + ToneW'(1);
          end
`endif
          if (unit_done) begin
            pin_d   = 1'b1;
            state_d = StGap;
          end
        end
        StGap, StSpace: begin
          if (unit_done) begin
            idx_d   = idx_q + CntW'(1);
            state_d = StLoad;
          end
        end
        StFin: begin
          if (Repeat) begin
            idx_d   = '0;
            state_d = StLoad;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
        default: begin
          pin_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // Prescaler and unit counter restart on every state entry so durations are exact.
  always_comb begin
    pre_d  = '0;
    unit_d = '0;
    if ((state_d == state_q) && (state_q != StIdle)) begin
      if (pre_q == PreLast) begin
        unit_d = unit_q + UnitW'(1);
      end else begin
        pre_d  = pre_q + PreW'(1);
        unit_d = unit_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      pre_q       <= '0;
      unit_q      <= '0;
      mark_last_q <= '0;
      pin_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MORSE_TONE_EN
      tone_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pre_q       <= pre_d;
      unit_q      <= unit_d;
      mark_last_q <= mark_last_d;
      pin_q       <= pin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MORSE_TONE_EN
      tone_q      <= tone_d;
`endif
    end
  end

  assign Pin_Out = pin_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_morse_pattern_player.sv
// Bench for morse_pattern_player: per-cycle waveform model plus directed and random stimulus.
module tb_morse_pattern_player;

  localparam int unsigned U    = 10;
  localparam int unsigned DOT  = 2;
  localparam int unsigned DASH = 6;
  localparam int unsigned GAP  = 1;
  localparam int unsigned WORD = 4;
  localparam int unsigned MS   = 16;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        Repeat = 1'b0;
  logic [31:0] Pattern = '0;
  logic [4:0]  Sym_Cnt = '0;
  logic        Pin_Out, Busy, Done;

  morse_pattern_player #(
    .UNIT_CYC  (U),
    .DOT_UNITS (DOT),
    .DASH_UNITS(DASH),
    .GAP_UNITS (GAP),
    .WORD_UNITS(WORD),
    .MAX_SYM   (MS),
    .TONE_HALF (4)
  ) u_dut (
    .CLK    (clk),
    .RST    (RST),
    .Start  (Start),
    .Stop   (Stop),
    .Repeat (Repeat),
    .Pattern(Pattern),
    .Sym_Cnt(Sym_Cnt),
    .Pin_Out(Pin_Out),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: one pass is a flat list of pin levels, first LOAD through FIN.
  bit wave[$];
  bit m_act = 1'b0;
  int m_pos = 0;
  bit exp_pin = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;

  int busy_cnt = 0, low_cnt = 0, done_cnt = 0;
  int b0, l0, d0;

  function automatic void build_wave(input logic [31:0] pat, input logic [4:0] sc);
    int n;
    int len;
    logic [1:0] s;
    wave.delete();
    n = (sc > 5'(MS)) ? MS : int'(sc);
    wave.push_back(1'b1);
    for (int k = 0; k < n; k++) begin
      s = pat[2*k +: 2];
      if (s == 2'b11) break;
      if (s == 2'b10) begin
        repeat (WORD * U) wave.push_back(1'b1);
      end else begin
        len = (s == 2'b00) ? DOT : DASH;
        repeat (len * U) wave.push_back(1'b0);
        repeat (GAP * U) wave.push_back(1'b1);
      end
      wave.push_back(1'b1);
    end
    wave.push_back(1'b1);
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic cycle_check();
    if (chk_en) begin
      tests++;
      if ({Pin_Out, Busy, Done} !== {exp_pin, exp_busy, exp_done}) begin
        fails++;
        $display("FAIL cycle @%0t: pin/busy/done got %b%b%b, expected %b%b%b", $time,
                 Pin_Out, Busy, Done, exp_pin, exp_busy, exp_done);
      end
      if (Busy === 1'b1) busy_cnt++;
      if (Pin_Out === 1'b0) low_cnt++;
      if (Done === 1'b1) done_cnt++;
    end
    // Predict outputs after the coming edge from the inputs now stable.
    if (RST) begin
      m_act = 1'b0;
      {exp_pin, exp_busy, exp_done} = 3'b100;
    end else if (m_act && Stop) begin
      m_act = 1'b0;
      {exp_pin, exp_busy, exp_done} = 3'b100;
    end else if (!m_act) begin
      {exp_pin, exp_busy, exp_done} = 3'b100;
      if (Start && !Stop) begin
        build_wave(Pattern, Sym_Cnt);
        m_act = 1'b1;
        m_pos = 0;
        exp_pin  = wave[0];
        exp_busy = 1'b1;
      end
    end else if (m_pos == wave.size() - 1) begin
      if (Repeat) begin
        m_pos = 0;
        exp_pin  = wave[0];
        exp_busy = 1'b1;
        exp_done = 1'b0;
      end else begin
        m_act = 1'b0;
        {exp_pin, exp_busy, exp_done} = 3'b101;
      end
    end else begin
      m_pos++;
      exp_pin  = wave[m_pos];
      exp_busy = 1'b1;
      exp_done = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b0 = busy_cnt;
    l0 = low_cnt;
    d0 = done_cnt;
  endtask

  task automatic start_msg(input logic [31:0] pat, input logic [4:0] sc, input logic rep);
    Pattern = pat;
    Sym_Cnt = sc;
    Repeat  = rep;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (Busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL %s timeout: Busy still %b after %0d cycles, expected 0", name, Busy, n);
    end
    tick();
  endtask

  task automatic run_msg(input string name, input logic [31:0] pat, input logic [4:0] sc,
                         input int exp_busy_cyc, input int exp_low_cyc);
    snap();
    start_msg(pat, sc, 1'b0);
    wait_idle(3000, name);
    check_int({name, " busy cycles"}, busy_cnt - b0, exp_busy_cyc);
    check_int({name, " low cycles"}, low_cnt - l0, exp_low_cyc);
    check_int({name, " done pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int n;
    tick();
    chk_en = 1'b1;
    check_bit("reset pin", Pin_Out, 1'b1);
    check_bit("reset busy", Busy, 1'b0);
    check_bit("reset done", Done, 1'b0);
    RST = 1'b0;
    tick();

    run_msg("sos", 32'h0000_0540, 5'd9, 401, 300);
    run_msg("zero count", 32'h0000_0000, 5'd0, 2, 0);
    run_msg("end marker", 32'h0000_00C8, 5'd5, 105, 40);
    run_msg("clamp", 32'h0000_0000, 5'd31, 498, 320);

    // Auto-repeat single dot, then release Repeat.
    snap();
    start_msg(32'h0, 5'd1, 1'b1);
    repeat (100) tick();
    check_bit("repeat busy", Busy, 1'b1);
    check_int("repeat no done", done_cnt - d0, 0);
    Repeat = 1'b0;
    wait_idle(100, "repeat release");
    check_int("repeat final done", done_cnt - d0, 1);

    // Stop mid-dash.
    snap();
    start_msg(32'h1, 5'd1, 1'b0);
    repeat (20) tick();
    check_bit("mid dash pin", Pin_Out, 1'b0);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check_bit("stop pin", Pin_Out, 1'b1);
    check_bit("stop busy", Busy, 1'b0);
    repeat (3) tick();
    check_int("stop no done", done_cnt - d0, 0);
    run_msg("restart after stop", 32'h0, 5'd0, 2, 0);

    // Stop and Start together in idle: nothing starts.
    Start = 1'b1;
    Stop  = 1'b1;
    tick();
    Start = 1'b0;
    Stop  = 1'b0;
    check_bit("stop beats start", Busy, 1'b0);
    tick();

    // Start held and inputs scrambled while busy.
    Pattern = 32'h0000_0540;
    Sym_Cnt = 5'd9;
    Start   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      Pattern = $urandom;
      Sym_Cnt = 5'($urandom_range(0, 31));
    end while (Done !== 1'b1 && n < 1000);
    Start = 1'b0;
    check_int("held start cycles to done", n, 402);
    tick();

    // Reset mid-mark.
    start_msg(32'h0, 5'd1, 1'b0);
    repeat (5) tick();
    check_bit("mid mark pin", Pin_Out, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_bit("rst pin", Pin_Out, 1'b1);
    check_bit("rst busy", Busy, 1'b0);
    check_bit("rst done", Done, 1'b0);
    tick();

    // Random traffic.
    for (int c = 0; c < 25000; c++) begin
      Start   = ($urandom_range(0, 9) == 0);
      Stop    = ($urandom_range(0, 399) == 0);
      Repeat  = ($urandom_range(0, 5) == 0);
      RST     = ($urandom_range(0, 1999) == 0);
      Pattern = $urandom;
      Sym_Cnt = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(0, 5));
      tick();
    end
    {Start, Stop, Repeat, RST} = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
